// File: rtl/spi_slave_16_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_16_if
// Purpose  : Bundles the SPI pins and the local parallel word exchange of the
//            spi_slave_16 responder.
// Ports    : SelectMode (CPOL/CPHA), SCLK/SS_n/MOSI from the master,
//            MISO to the master, Tx_Data/Tx_Load/Tx_Ready transmit buffer
//            handshake, Rx_Data/Rx_Valid receive word, Busy status.
//            Modport slave  : the responder side.
//            Modport master : the SPI master plus local logic driving it.
// Revision : 1.0  initial release
// ============================================================================
interface spi_slave_16_if #(
    parameter int WIDTH = 16
) ();
    logic [1:0]       SelectMode;
    logic             SCLK;
    logic             SS_n;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] Tx_Data;
    logic             Tx_Load;
    logic             Tx_Ready;
    logic [WIDTH-1:0] Rx_Data;
    logic             Rx_Valid;
    logic             Busy;

    modport slave (
        input  SelectMode, SCLK, SS_n, MOSI, Tx_Data, Tx_Load,
        output MISO, Tx_Ready, Rx_Data, Rx_Valid, Busy
    );

    modport master (
        output SelectMode, SCLK, SS_n, MOSI, Tx_Data, Tx_Load,
        input  MISO, Tx_Ready, Rx_Data, Rx_Valid, Busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_16.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_16
// Purpose  : SPI responder. Oversamples SCLK/SS_n/MOSI on clk, shifts WIDTH-bit
//            words MSB-first in all four SPI modes, one-deep tx buffer and a
//            one-cycle receive-valid pulse.
// Ports    : clk    - system clock, all state on posedge
//            Reset  - asynchronous active-low reset
//            bus    - spi_slave_16_if.slave (pins + parallel word exchange)
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_16 #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic     clk,
    input  wire logic     Reset,
    spi_slave_16_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_rise_q, sclk_fall_q, ss_rise_q, ss_fall_q;
    logic [1:0]             mode_q;
    logic [WIDTH-1:0]       tx_buf_q, tx_shift_q, rx_shift_q, rx_data_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tx_full_q, miso_q, rx_valid_q, busy_q;

    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   mosi_s, load_go, tx_accept;
    logic [WIDTH-1:0]       tx_word_d, rx_word_d;

    // ------------------------------------------------------------------
    // Pin synchronizers followed by a registered edge detector. The SCLK
    // chain resets to the idle level of the current mode so leaving reset
    // does not look like a clock edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sclk_sync_q <= {SYNC_STAGES{bus.SelectMode[1]}};
            sclk_prev_q <= bus.SelectMode[1];
            ss_sync_q   <= '1;
            ss_prev_q   <= 1'b1;
            mosi_sync_q <= '0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ss_rise_q   <= 1'b0;
            ss_fall_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
            sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
            ss_rise_q   <= ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
            ss_fall_q   <= ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
        end
    end

    // Leading edge leaves the CPOL level; CPHA picks which edge samples.
    assign lead_edge   = mode_q[1] ? sclk_fall_q : sclk_rise_q;
    assign trail_edge  = mode_q[1] ? sclk_rise_q : sclk_fall_q;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_q[0] ? lead_edge  : trail_edge;
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    assign tx_word_d   = tx_full_q ? tx_buf_q : '0;
    assign rx_word_d   = {rx_shift_q[WIDTH-2:0], mosi_s};

    // A LOAD that is not being aborted frees the buffer in the same cycle,
    // so a concurrent Tx_Load is accepted even though Tx_Ready reads 0.
    assign load_go     = (state_q == LOAD) && !ss_rise_q;
    assign tx_accept   = bus.Tx_Load && (!tx_full_q || load_go);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rx_valid_q <= 1'b0;

            if (tx_accept) begin
                tx_buf_q  <= bus.Tx_Data;
                tx_full_q <= 1'b1;
            end else if (load_go) begin
                tx_full_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (ss_fall_q) begin
                        mode_q  <= bus.SelectMode;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    if (ss_rise_q) begin
                        state_q    <= IDLE;
                        miso_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        rx_shift_q <= '0;
                    end else begin
                        // CPHA=0 presents the MSB right away; the remaining
                        // bits follow on trailing edges.
                        if (!mode_q[0]) begin
                            miso_q     <= tx_word_d[WIDTH-1];
                            tx_shift_q <= {tx_word_d[WIDTH-2:0], 1'b0};
                        end else begin
                            tx_shift_q <= tx_word_d;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (ss_rise_q) begin
                        state_q    <= IDLE;
                        miso_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        rx_shift_q <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_word_d;
                            if (cnt_q == CNT_LAST) begin
                                rx_data_q  <= rx_word_d;
                                rx_valid_q <= 1'b1;
                                cnt_q      <= '0;
                                busy_q     <= 1'b0;
                                state_q    <= LOAD;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                        // In CPHA=0 the trailing edge after the last sample
                        // (counter wrapped to 0) belongs to no bit and must
                        // not disturb the MSB already placed by LOAD.
                        if (shift_edge && (mode_q[0] || cnt_q != '0)) begin
                            miso_q     <= tx_shift_q[WIDTH-1];
                            tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.Tx_Ready = ~tx_full_q;
    assign bus.Rx_Data  = rx_data_q;
    assign bus.Rx_Valid = rx_valid_q;
    assign bus.Busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_16
// Purpose  : Self-checking bench for spi_slave_16: a vector table of single
//            word transfers in all modes plus sequences for back-to-back
//            words, abort and reset mid-word.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_16;
    localparam int HALF = 10;   // SCLK half period in clk cycles

    logic clk;
    logic Reset;

    spi_slave_16_if #(.WIDTH(16)) bus ();

    spi_slave_16 #(
        .WIDTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          rv_count;
    logic [15:0] rv_data;

    initial begin
        rv_count = 0;
        rv_data  = '0;
    end

    always @(negedge clk) begin
        if (bus.Rx_Valid === 1'b1) begin
            rv_count = rv_count + 1;
            rv_data  = bus.Rx_Data;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_idle(input logic [1:0] mode);
        bus.SelectMode = mode;
        bus.SCLK       = mode[1];
        bus.SS_n       = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic tx_load(input logic [15:0] d);
        bus.Tx_Data = d;
        bus.Tx_Load = 1'b1;
        wait_clk(1);
        bus.Tx_Load = 1'b0;
        wait_clk(1);
    endtask

    task automatic select_slave();
        bus.SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic deselect_slave();
        bus.SS_n = 1'b1;
        wait_clk(HALF + 2);
    endtask

    // SPI master: drives MOSI on its shift edge, captures MISO on its sample edge.
    task automatic xfer(input logic [1:0] mode, input logic [15:0] mosi_w,
                        input int nbits, output logic [15:0] miso_w);
        logic cpol;
        logic cpha;
        cpol   = mode[1];
        cpha   = mode[0];
        miso_w = '0;
        if (!cpha) bus.MOSI = mosi_w[15];
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) miso_w[15-i] = bus.MISO;
            bus.SCLK = ~cpol;
            if (cpha) bus.MOSI = mosi_w[15-i];
            wait_clk(HALF);
            if (cpha) miso_w[15-i] = bus.MISO;
            bus.SCLK = cpol;
            if (!cpha && i < 15) bus.MOSI = mosi_w[14-i];
            wait_clk(HALF);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        load;
        logic [15:0] tx;
        logic [15:0] rx;
        logic [15:0] exp_miso;
        logic        exp_first;   // MISO just before the first leading edge
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] m1, m2;
    int          start;

    initial begin
        vecs[0] = '{mode: 2'd0, load: 1'b1, tx: 16'h3C96, rx: 16'hA55A, exp_miso: 16'h3C96, exp_first: 1'b0};
        vecs[1] = '{mode: 2'd1, load: 1'b1, tx: 16'h8001, rx: 16'h7FFE, exp_miso: 16'h8001, exp_first: 1'b0};
        vecs[2] = '{mode: 2'd2, load: 1'b1, tx: 16'h8001, rx: 16'h7FFE, exp_miso: 16'h8001, exp_first: 1'b1};
        vecs[3] = '{mode: 2'd3, load: 1'b1, tx: 16'h8001, rx: 16'h7FFE, exp_miso: 16'h8001, exp_first: 1'b0};
        vecs[4] = '{mode: 2'd0, load: 1'b0, tx: 16'hFFFF, rx: 16'h5A0F, exp_miso: 16'h0000, exp_first: 1'b0};
        vecs[5] = '{mode: 2'd3, load: 1'b0, tx: 16'hFFFF, rx: 16'hC3A5, exp_miso: 16'h0000, exp_first: 1'b0};

        checks         = 0;
        errors         = 0;
        Reset          = 1'b0;
        bus.SelectMode = 2'd0;
        bus.SCLK       = 1'b0;
        bus.SS_n       = 1'b1;
        bus.MOSI       = 1'b0;
        bus.Tx_Data    = '0;
        bus.Tx_Load    = 1'b0;
        wait_clk(3);

        chk("reset_miso",     bus.MISO,     1'b0);
        chk("reset_tx_ready", bus.Tx_Ready, 1'b1);
        chk("reset_rx_data",  bus.Rx_Data,  16'h0000);
        chk("reset_rx_valid", bus.Rx_Valid, 1'b0);
        chk("reset_busy",     bus.Busy,     1'b0);
        Reset = 1'b1;
        wait_clk(5);

        // ---------------- table-driven single words ----------------
        for (int k = 0; k < 6; k++) begin
            set_idle(vecs[k].mode);
            start = rv_count;
            if (vecs[k].load) begin
                tx_load(vecs[k].tx);
                chk("tx_ready_after_load", bus.Tx_Ready, 1'b0);
            end
            select_slave();
            chk("first_miso_bit", bus.MISO, vecs[k].exp_first);
            chk("busy_active",    bus.Busy, 1'b1);
            chk("tx_ready_after_sel", bus.Tx_Ready, 1'b1);
            xfer(vecs[k].mode, vecs[k].rx, 16, m1);
            chk("rx_valid_pulses", rv_count - start, 1);
            chk("rx_data",         rv_data,          vecs[k].rx);
            chk("miso_word",       m1,               vecs[k].exp_miso);
            deselect_slave();
            chk("busy_idle",       bus.Busy, 1'b0);
            chk("miso_idle",       bus.MISO, 1'b0);
        end

        // ---------------- back-to-back words, mode 0 ----------------
        set_idle(2'd0);
        start = rv_count;
        tx_load(16'h1111);
        select_slave();
        tx_load(16'h2222);
        chk("b2b_tx_ready", bus.Tx_Ready, 1'b0);
        xfer(2'd0, 16'h1234, 16, m1);
        chk("b2b_w1_pulses", rv_count - start, 1);
        chk("b2b_w1_rx",     rv_data,          16'h1234);
        chk("b2b_w1_miso",   m1,               16'h1111);
        xfer(2'd0, 16'hFEDC, 16, m2);
        chk("b2b_w2_pulses", rv_count - start, 2);
        chk("b2b_w2_rx",     rv_data,          16'hFEDC);
        chk("b2b_w2_miso",   m2,               16'h2222);
        deselect_slave();

        // ---------------- abort after 7 bits ----------------
        set_idle(2'd0);
        start = rv_count;
        select_slave();
        xfer(2'd0, 16'hFFFF, 7, m1);
        deselect_slave();
        chk("abort_no_valid", rv_count - start, 0);
        chk("abort_busy",     bus.Busy,         1'b0);
        chk("abort_rx_kept",  bus.Rx_Data,      16'h2222 ^ 16'h2222 ^ 16'hFEDC);
        select_slave();
        xfer(2'd0, 16'h00FF, 16, m1);
        deselect_slave();
        chk("after_abort_pulses", rv_count - start, 1);
        chk("after_abort_rx",     rv_data,          16'h00FF);

        // ---------------- reset mid-word ----------------
        set_idle(2'd1);
        start = rv_count;
        select_slave();
        tx_load(16'hABCD);
        chk("mid_tx_ready", bus.Tx_Ready, 1'b0);
        xfer(2'd1, 16'hBEEF, 5, m1);
        Reset = 1'b0;
        wait_clk(1);
        chk("rst_miso",     bus.MISO,     1'b0);
        chk("rst_tx_ready", bus.Tx_Ready, 1'b1);
        chk("rst_rx_data",  bus.Rx_Data,  16'h0000);
        chk("rst_rx_valid", bus.Rx_Valid, 1'b0);
        chk("rst_busy",     bus.Busy,     1'b0);
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b0;
        wait_clk(5);
        Reset = 1'b1;
        wait_clk(HALF);
        chk("rst_no_valid", rv_count - start, 0);
        select_slave();
        xfer(2'd1, 16'hBEEF, 16, m1);
        deselect_slave();
        chk("post_rst_pulses", rv_count - start, 1);
        chk("post_rst_rx",     rv_data,          16'hBEEF);
        chk("post_rst_miso",   m1,               16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_16.md
# spi_slave_16

SPI responder (slave) transceiver: the far end of the SPI link driven by the team's master-side clock counter and shifter. Oversamples the external SCLK, SS_n and MOSI pins on the local system clock, shifts 16-bit words MSB-first in all four SPI modes, and exchanges parallel words with local logic through a one-deep transmit buffer and a receive-valid pulse. Sits between the SPI pins and the local register/data path.

## Interface
- WIDTH, 16: word length in bits; bit counter runs 0..WIDTH-1.
- SYNC_STAGES, 2: flip-flop stages on each asynchronous input pin, minimum 2.

- clk  input  1  system clock; all state is on posedge clk.
- Reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- SelectMode  input  2  SPI mode; bit1 = CPOL, bit0 = CPHA; sampled only while idle.
- SCLK  input  1  serial clock from master, asynchronous.
- SS_n  input  1  slave select, active-low, asynchronous.
- MOSI  input  1  serial data from master, asynchronous.
- MISO  output  1  serial data to master.
- Tx_Data  input  WIDTH  word to transmit.
- Tx_Load  input  1  writes Tx_Data into the tx buffer when Tx_Ready = 1.
- Tx_Ready  output  1  tx buffer empty.
- Rx_Data  output  WIDTH  last complete received word.
- Rx_Valid  output  1  one-cycle pulse: Rx_Data updated.
- Busy  output  1  a transfer is in progress (state ACTIVE).

## Operation
- Reset values: MISO 0, Tx_Ready 1, Rx_Data 0, Rx_Valid 0, Busy 0, bit counter 0, shift registers 0, synchronizers at idle (SS_n 1, SCLK = CPOL of current SelectMode, MOSI 0), state IDLE.
- SCLK, SS_n and MOSI pass through SYNC_STAGES flops, then one edge-detect flop. Leading edge = synced SCLK leaving CPOL level; trailing edge = returning to it.
- Sample edge: leading if CPHA = 0, trailing if CPHA = 1. Shift (MISO update) edge: the other one.
- Mode latch: SelectMode is captured on SS_n falling edge and held for the whole selection.
- FSM IDLE: Busy 0, MISO 0. Synced SS_n falling edge -> LOAD.
- FSM LOAD (one cycle): shift-out register <= tx buffer if full, else all zeros; tx buffer marked empty (Tx_Ready 1 next cycle); bit counter 0. If CPHA = 0, MISO <= MSB now. -> ACTIVE.
- FSM ACTIVE: Busy 1. On sample edge: rx shift <= {rx shift[WIDTH-2:0], MOSI}, counter +1. On shift edge: MISO <= next bit (CPHA = 1: first leading edge drives the MSB). When the sample of bit WIDTH-1 completes: Rx_Data <= assembled word, Rx_Valid pulses one cycle, counter wraps to 0, -> LOAD (back-to-back word if SS_n stays low).
- Synced SS_n rising in ACTIVE or LOAD: abort; partial word discarded, no Rx_Valid, counter 0, MISO 0, -> IDLE. A shift register already loaded from the tx buffer is lost (not restored).
- Tx buffer: Tx_Load with Tx_Ready 1 captures Tx_Data, Tx_Ready 0 next cycle. Tx_Load with Tx_Ready 0 ignored. Tx_Load in the same cycle as LOAD empties the buffer: LOAD takes the old content (or zeros); the new word is captured, Tx_Ready 0.
- Rx has no back-pressure: Rx_Data is overwritten by each completed word.
- Reset low mid-transfer: immediate return to reset values; no Rx_Valid.

## Timing
- Pin-to-detect latency: SYNC_STAGES + 1 clk (3 with defaults).
- Rx_Valid asserts SYNC_STAGES + 2 clk after the pin-level final sample edge; Rx_Data valid in the same cycle.
- MISO changes SYNC_STAGES + 2 clk after the pin-level shift edge.
- SCLK high and low phases each >= 2·(SYNC_STAGES + 2) clk (8 clk with defaults); SS_n falling to first SCLK edge >= the same.
- Back-to-back words: LOAD costs one clk and must fit inside the SCLK phase after the last sample edge; guaranteed by the phase rule above.

## Test plan
- Mode 0, Tx_Load 0x3C96, master sends 0xA55A: Rx_Data 0xA55A with one Rx_Valid pulse; master captures 0x3C96; Tx_Ready 1 after LOAD.
- Repeat in modes 1, 2, 3 with tx 0x8001, rx 0x7FFE: same results; SCLK idle level and first MISO bit timing match CPOL/CPHA.
- Two words in one SS_n low (rx 0x1234, 0xFEDC; tx 0x1111 then 0x2222 loaded during word 1): two Rx_Valid pulses, correct data both directions.
- Tx buffer empty at selection: MISO shifts 0x0000; Rx still correct.
- SS_n raised after 7 bits, then full word 0x00FF: no Rx_Valid for abort; next Rx_Data 0x00FF.
- Reset low mid-word, then released, then word 0xBEEF: all outputs at reset values during reset; Rx_Data 0xBEEF afterward.
